stage_1_inverse_permutation: RTL and testbench
==============================================

STAGE_1_INVERSE_PERMUTATION -- requirements
Module: stage_1_inverse_permutation

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH_PER_INPUT, default 28, meaning the width of one lane word.
REQ-002 The module SHALL have parameter INPUT_PER_CYCLE, default 64, meaning the lanes per beat (fixed at 64).
REQ-003 The module SHALL have parameter BEATS_PER_FRAME, default 32, meaning the beats per 2048-point frame.
REQ-004 The module SHALL have port clk, input, width 1: the single clock.
REQ-005 The module SHALL have port rst, input, width 1: reset, asynchronous, active-low.
REQ-006 The module SHALL have ports inData_0 .. inData_63, input, each DATA_WIDTH_PER_INPUT wide: the lane words in permuted order.
REQ-007 The module SHALL have port in_start, input, width 1: marks beat 0 of an input frame.
REQ-008 The module SHALL have ports outData_0 .. outData_63, output, each DATA_WIDTH_PER_INPUT wide: the lane words in natural order.
REQ-009 The module SHALL have port out_start, output, width 1: marks beat 0 of an output frame.
REQ-010 The module SHALL have port out_valid, output, width 1: high on every beat of an output frame.
REQ-011 The module SHALL have port out_beat, output, width 5: the beat index 0..31 of the current output word.
REQ-012 The module SHALL have port frame_err, output, width 1: a one-cycle pulse on a premature restart.

Function
REQ-013 The lane map SHALL be: for lane k = 8g + 4b2 + 2b1 + b0, outData_k takes inData_(8g + 4b0 + 2b1 + b2), i.e. bits 0 and 2 of the lane index are swapped within each 8-lane group.
REQ-014 This map SHALL be its own inverse, so stage-1 permuted data is restored to natural order.
REQ-015 Data latency SHALL be exactly 1 cycle, with one registered stage and no combinational input-to-output path.
REQ-016 The FSM SHALL have states IDLE and ACTIVE, together with a 5-bit beat counter.
REQ-017 IDLE, in_start=1 -> ACTIVE with counter=0; in_start=0 -> stay IDLE.
REQ-018 In ACTIVE, the counter SHALL increment by 1 per cycle.
REQ-019 When the counter is 31 and in_start=0, the FSM SHALL go to IDLE.
REQ-020 When the counter is 31 and in_start=1, the FSM SHALL stay ACTIVE with counter=0 (legal back-to-back frame) and raise no error.
REQ-021 When in_start=1 in ACTIVE with counter<31, the FSM SHALL restart with counter=0 and pulse frame_err one cycle later.
REQ-022 out_start SHALL equal in_start delayed 1 cycle.
REQ-023 out_valid SHALL equal (next state is ACTIVE) delayed 1 cycle.
REQ-024 out_beat SHALL equal the next counter value delayed 1 cycle, and SHALL be 0 while out_valid=0.
REQ-025 outData_* SHALL be registered every cycle regardless of state; out_valid qualifies the data.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, counter=0, all outData_*=0, out_start=0, out_valid=0, out_beat=0 and frame_err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no output beat of that frame SHALL appear after release.
REQ-028 After rst deasserts, the first in_start SHALL be accepted on the first rising edge.

Structure
REQ-029 Shared package ntt_perm_pkg SHALL hold N=2048, P=64, BEATS=32, the beat-index width (5) and the FSM state enum.
REQ-030 The package SHALL hold a pure lane-map function, shared with stage_1_permutation checkers.
REQ-031 The block SHALL need no sub-module: it is one flat module with one sequential process and the FSM next-state logic.

Verification
REQ-032 Scenario: inData_k=k for all k, in_start pulse -> next cycle outData_1=4, outData_4=1, outData_3=6, outData_6=3, outData_57=60, all others identity.
REQ-033 Scenario: cascade stage_1_permutation into this block with random data for 32 beats -> output equals the original input 2 cycles later, and out_valid is high for exactly 32 cycles.
REQ-034 Scenario: in_start at cycle 0 and again at cycle 32 -> out_valid high for 64 continuous cycles, out_beat wraps 31->0, frame_err stays 0.
REQ-035 Scenario: in_start at cycle 0 and again at cycle 10 -> frame_err=1 at cycle 11 only, and out_beat=0 at cycle 11.
REQ-036 Scenario: rst=0 asserted at beat 15 between clock edges -> all outputs 0 immediately, and out_valid stays 0 until the next in_start.
REQ-037 Scenario: no in_start after reset for 100 cycles -> out_valid=0, out_start=0, out_beat=0, while outData_* still tracks the mapped input with 1-cycle latency.

Source files
------------

// File: rtl/ntt_perm_pkg.sv
// Shared definitions for the NTT stage-1 lane permutation blocks: frame geometry,
// the beat FSM state type and the lane map used by both the permuter and its inverse.
package ntt_perm_pkg;

    localparam int N      = 2048;
    localparam int P      = 64;
    localparam int BEATS  = N / P;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LANE_W = $clog2(P);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fsm_state_e;

    // Swapping index bits 0 and 2 inside each 8-lane group is an involution,
    // so the same map serves the forward permutation and its inverse.
    function automatic logic [LANE_W-1:0] lane_map(input logic [LANE_W-1:0] lane);
        return {lane[LANE_W-1:3], lane[0], lane[1], lane[2]};
    endfunction

endpackage

// File: rtl/stage_1_inverse_permutation.sv
// Restores natural lane order after the stage-1 permutation, one registered stage,
// and tracks 32-beat frames to produce start/valid/beat framing and a restart error.
module stage_1_inverse_permutation
    import ntt_perm_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 64,
    parameter int BEATS_PER_FRAME      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,  inData_1,  inData_2,  inData_3,  inData_4,  inData_5,  inData_6,  inData_7,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,  inData_9,  inData_10, inData_11, inData_12, inData_13, inData_14, inData_15,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16, inData_17, inData_18, inData_19, inData_20, inData_21, inData_22, inData_23,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24, inData_25, inData_26, inData_27, inData_28, inData_29, inData_30, inData_31,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_32, inData_33, inData_34, inData_35, inData_36, inData_37, inData_38, inData_39,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_40, inData_41, inData_42, inData_43, inData_44, inData_45, inData_46, inData_47,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_48, inData_49, inData_50, inData_51, inData_52, inData_53, inData_54, inData_55,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_56, inData_57, inData_58, inData_59, inData_60, inData_61, inData_62, inData_63,
    input  logic                            in_start,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,  outData_1,  outData_2,  outData_3,  outData_4,  outData_5,  outData_6,  outData_7,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,  outData_9,  outData_10, outData_11, outData_12, outData_13, outData_14, outData_15,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16, outData_17, outData_18, outData_19, outData_20, outData_21, outData_22, outData_23,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24, outData_25, outData_26, outData_27, outData_28, outData_29, outData_30, outData_31,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_32, outData_33, outData_34, outData_35, outData_36, outData_37, outData_38, outData_39,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_40, outData_41, outData_42, outData_43, outData_44, outData_45, outData_46, outData_47,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_48, outData_49, outData_50, outData_51, outData_52, outData_53, outData_54, outData_55,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_56, outData_57, outData_58, outData_59, outData_60, outData_61, outData_62, outData_63,
    output logic                            out_start,
    output logic                            out_valid,
    output logic [BEAT_W-1:0]               out_beat,
    output logic                            frame_err,
    output fsm_state_e                      dbg_state
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);

    logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] in_w;
    logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] data_d, data_q;

    fsm_state_e        state_d, state_q;
    logic [BEAT_W-1:0] cnt_d, cnt_q;
    logic [BEAT_W-1:0] beat_d, beat_q;
    logic              err_d, err_q;
    logic              valid_d, valid_q;
    logic              start_d, start_q;

    assign in_w = {inData_63, inData_62, inData_61, inData_60, inData_59, inData_58, inData_57, inData_56,
                   inData_55, inData_54, inData_53, inData_52, inData_51, inData_50, inData_49, inData_48,
                   inData_47, inData_46, inData_45, inData_44, inData_43, inData_42, inData_41, inData_40,
                   inData_39, inData_38, inData_37, inData_36, inData_35, inData_34, inData_33, inData_32,
                   inData_31, inData_30, inData_29, inData_28, inData_27, inData_26, inData_25, inData_24,
                   inData_23, inData_22, inData_21, inData_20, inData_19, inData_18, inData_17, inData_16,
                   inData_15, inData_14, inData_13, inData_12, inData_11, inData_10, inData_9,  inData_8,
                   inData_7,  inData_6,  inData_5,  inData_4,  inData_3,  inData_2,  inData_1,  inData_0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (in_start) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // A start on the last beat is a legal back-to-back frame; earlier is an error.
                if (in_start) begin
                    cnt_d = '0;
                    err_d = (cnt_q != LAST_BEAT);
                end else if (cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        valid_d = (state_d == ST_ACTIVE);
        beat_d  = valid_d ? cnt_d : '0;
        start_d = in_start;
        for (int k = 0; k < INPUT_PER_CYCLE; k++) begin
            data_d[k] = in_w[lane_map(LANE_W'(k))];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= start_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign {outData_63, outData_62, outData_61, outData_60, outData_59, outData_58, outData_57, outData_56,
            outData_55, outData_54, outData_53, outData_52, outData_51, outData_50, outData_49, outData_48,
            outData_47, outData_46, outData_45, outData_44, outData_43, outData_42, outData_41, outData_40,
            outData_39, outData_38, outData_37, outData_36, outData_35, outData_34, outData_33, outData_32,
            outData_31, outData_30, outData_29, outData_28, outData_27, outData_26, outData_25, outData_24,
            outData_23, outData_22, outData_21, outData_20, outData_19, outData_18, outData_17, outData_16,
            outData_15, outData_14, outData_13, outData_12, outData_11, outData_10, outData_9,  outData_8,
            outData_7,  outData_6,  outData_5,  outData_4,  outData_3,  outData_2,  outData_1,  outData_0} = data_q;

    assign out_start = start_q;
    assign out_valid = valid_q;
    assign out_beat  = beat_q;
    assign frame_err = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stage_1_inverse_permutation.sv
// Bench for stage_1_inverse_permutation: lane-map table, framing corner cases,
// asynchronous reset and random traffic checked against an arithmetic frame model.
module tb_stage_1_inverse_permutation;
    import ntt_perm_pkg::*;

    localparam int W = 28;
    localparam int L = 64;
    localparam int FRAME = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic [W-1:0] in_a  [L];
    logic [W-1:0] out_a [L];
    logic         out_start, out_valid, frame_err;
    logic [4:0]   out_beat;
    fsm_state_e   dbg_state;

    int checks = 0;
    int passes = 0;
    int pos = -1;           // model: beat index of the frame in flight, -1 when idle
    int valid_cycles = 0;
    int err_cycles = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int lane;
        int exp_val;
    } map_vec_t;
    map_vec_t map_tab[12];

    always #5 clk = ~clk;

    stage_1_inverse_permutation #(
        .DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(L), .BEATS_PER_FRAME(FRAME)
    ) dut (
        .clk(clk), .rst(rst), .in_start(in_start),
        .inData_0(in_a[0]),   .inData_1(in_a[1]),   .inData_2(in_a[2]),   .inData_3(in_a[3]),
        .inData_4(in_a[4]),   .inData_5(in_a[5]),   .inData_6(in_a[6]),   .inData_7(in_a[7]),
        .inData_8(in_a[8]),   .inData_9(in_a[9]),   .inData_10(in_a[10]), .inData_11(in_a[11]),
        .inData_12(in_a[12]), .inData_13(in_a[13]), .inData_14(in_a[14]), .inData_15(in_a[15]),
        .inData_16(in_a[16]), .inData_17(in_a[17]), .inData_18(in_a[18]), .inData_19(in_a[19]),
        .inData_20(in_a[20]), .inData_21(in_a[21]), .inData_22(in_a[22]), .inData_23(in_a[23]),
        .inData_24(in_a[24]), .inData_25(in_a[25]), .inData_26(in_a[26]), .inData_27(in_a[27]),
        .inData_28(in_a[28]), .inData_29(in_a[29]), .inData_30(in_a[30]), .inData_31(in_a[31]),
        .inData_32(in_a[32]), .inData_33(in_a[33]), .inData_34(in_a[34]), .inData_35(in_a[35]),
        .inData_36(in_a[36]), .inData_37(in_a[37]), .inData_38(in_a[38]), .inData_39(in_a[39]),
        .inData_40(in_a[40]), .inData_41(in_a[41]), .inData_42(in_a[42]), .inData_43(in_a[43]),
        .inData_44(in_a[44]), .inData_45(in_a[45]), .inData_46(in_a[46]), .inData_47(in_a[47]),
        .inData_48(in_a[48]), .inData_49(in_a[49]), .inData_50(in_a[50]), .inData_51(in_a[51]),
        .inData_52(in_a[52]), .inData_53(in_a[53]), .inData_54(in_a[54]), .inData_55(in_a[55]),
        .inData_56(in_a[56]), .inData_57(in_a[57]), .inData_58(in_a[58]), .inData_59(in_a[59]),
        .inData_60(in_a[60]), .inData_61(in_a[61]), .inData_62(in_a[62]), .inData_63(in_a[63]),
        .outData_0(out_a[0]),   .outData_1(out_a[1]),   .outData_2(out_a[2]),   .outData_3(out_a[3]),
        .outData_4(out_a[4]),   .outData_5(out_a[5]),   .outData_6(out_a[6]),   .outData_7(out_a[7]),
        .outData_8(out_a[8]),   .outData_9(out_a[9]),   .outData_10(out_a[10]), .outData_11(out_a[11]),
        .outData_12(out_a[12]), .outData_13(out_a[13]), .outData_14(out_a[14]), .outData_15(out_a[15]),
        .outData_16(out_a[16]), .outData_17(out_a[17]), .outData_18(out_a[18]), .outData_19(out_a[19]),
        .outData_20(out_a[20]), .outData_21(out_a[21]), .outData_22(out_a[22]), .outData_23(out_a[23]),
        .outData_24(out_a[24]), .outData_25(out_a[25]), .outData_26(out_a[26]), .outData_27(out_a[27]),
        .outData_28(out_a[28]), .outData_29(out_a[29]), .outData_30(out_a[30]), .outData_31(out_a[31]),
        .outData_32(out_a[32]), .outData_33(out_a[33]), .outData_34(out_a[34]), .outData_35(out_a[35]),
        .outData_36(out_a[36]), .outData_37(out_a[37]), .outData_38(out_a[38]), .outData_39(out_a[39]),
        .outData_40(out_a[40]), .outData_41(out_a[41]), .outData_42(out_a[42]), .outData_43(out_a[43]),
        .outData_44(out_a[44]), .outData_45(out_a[45]), .outData_46(out_a[46]), .outData_47(out_a[47]),
        .outData_48(out_a[48]), .outData_49(out_a[49]), .outData_50(out_a[50]), .outData_51(out_a[51]),
        .outData_52(out_a[52]), .outData_53(out_a[53]), .outData_54(out_a[54]), .outData_55(out_a[55]),
        .outData_56(out_a[56]), .outData_57(out_a[57]), .outData_58(out_a[58]), .outData_59(out_a[59]),
        .outData_60(out_a[60]), .outData_61(out_a[61]), .outData_62(out_a[62]), .outData_63(out_a[63]),
        .out_start(out_start), .out_valid(out_valid), .out_beat(out_beat),
        .frame_err(frame_err), .dbg_state(dbg_state)
    );

    // Natural-order lane k comes from the lane whose low three index bits are reversed.
    function automatic int src_lane(input int k);
        int g;
        int r;
        g = k / 8;
        r = k % 8;
        return g * 8 + (r % 2) * 4 + ((r / 2) % 2) * 2 + (r / 4);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_reset(input string name);
        int nz;
        nz = 0;
        for (int k = 0; k < L; k++) if (out_a[k] !== '0) nz++;
        chk({name, "_valid"}, longint'(out_valid), 0);
        chk({name, "_start"}, longint'(out_start), 0);
        chk({name, "_beat"}, longint'(out_beat), 0);
        chk({name, "_err"}, longint'(frame_err), 0);
        chk({name, "_state"}, longint'(dbg_state), longint'(ST_IDLE));
        chk({name, "_nonzero_lanes"}, nz, 0);
    endtask

    // mode 0: random lanes, 1: inData_k = k, 2: random source fed through the forward permutation
    task automatic run_cycle(input logic st, input int mode);
        logic [W-1:0] orig [L];
        logic         exp_err;
        logic         exp_valid;
        int           exp_beat;
        int           bad;
        for (int k = 0; k < L; k++) orig[k] = (mode == 1) ? W'(k) : W'($urandom);
        for (int k = 0; k < L; k++) in_a[k] = (mode == 2) ? orig[src_lane(k)] : orig[k];
        for (int k = 0; k < L; k++) exp_q.push_back((mode == 2) ? orig[k] : in_a[src_lane(k)]);
        in_start = st;
        exp_err = st && (pos >= 0) && (pos < FRAME - 1);
        if (st) pos = 0;
        else if (pos >= 0) begin
            pos++;
            if (pos == FRAME) pos = -1;
        end
        exp_valid = (pos >= 0);
        exp_beat  = exp_valid ? pos : 0;
        @(posedge clk);
        #1;
        chk("out_valid", longint'(out_valid), longint'(exp_valid));
        chk("out_beat", longint'(out_beat), exp_beat);
        chk("out_start", longint'(out_start), longint'(st));
        chk("frame_err", longint'(frame_err), longint'(exp_err));
        chk("dbg_state", longint'(dbg_state), exp_valid ? longint'(ST_ACTIVE) : longint'(ST_IDLE));
        bad = 0;
        for (int k = 0; k < L; k++) if (out_a[k] !== exp_q.pop_front()) bad++;
        chk("lane_mismatches", bad, 0);
        if (out_valid) valid_cycles++;
        if (frame_err) err_cycles++;
    endtask

    initial begin
        map_tab[0]  = '{1, 4};   map_tab[1]  = '{4, 1};   map_tab[2]  = '{3, 6};
        map_tab[3]  = '{6, 3};   map_tab[4]  = '{57, 60}; map_tab[5]  = '{60, 57};
        map_tab[6]  = '{0, 0};   map_tab[7]  = '{2, 2};   map_tab[8]  = '{5, 5};
        map_tab[9]  = '{7, 7};   map_tab[10] = '{14, 11}; map_tab[11] = '{63, 63};

        rst = 1'b0;
        in_start = 1'b0;
        for (int k = 0; k < L; k++) in_a[k] = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // Start accepted on the very first edge after release, with identity lane data.
        run_cycle(1'b1, 1);
        for (int i = 0; i < 12; i++)
            chk($sformatf("lane_map_%0d", map_tab[i].lane), longint'(out_a[map_tab[i].lane]), map_tab[i].exp_val);
        repeat (31) run_cycle(1'b0, 0);
        repeat (2) run_cycle(1'b0, 0);

        // Cascade with the forward permutation: a single frame restores the source words.
        valid_cycles = 0;
        run_cycle(1'b1, 2);
        repeat (31) run_cycle(1'b0, 2);
        repeat (3) run_cycle(1'b0, 2);
        chk("cascade_valid_cycles", valid_cycles, 32);

        // Back-to-back frames: start at cycle 0 and cycle 32.
        valid_cycles = 0;
        err_cycles = 0;
        run_cycle(1'b1, 0);
        repeat (31) run_cycle(1'b0, 0);
        run_cycle(1'b1, 0);
        chk("b2b_wrap_beat", longint'(out_beat), 0);
        chk("b2b_wrap_valid", longint'(out_valid), 1);
        repeat (31) run_cycle(1'b0, 0);
        repeat (3) run_cycle(1'b0, 0);
        chk("b2b_valid_cycles", valid_cycles, 64);
        chk("b2b_err_cycles", err_cycles, 0);

        // Premature restart at cycle 10.
        err_cycles = 0;
        run_cycle(1'b1, 0);
        repeat (9) run_cycle(1'b0, 0);
        run_cycle(1'b1, 0);
        chk("premature_err", longint'(frame_err), 1);
        chk("premature_beat", longint'(out_beat), 0);
        repeat (34) run_cycle(1'b0, 0);
        chk("premature_err_cycles", err_cycles, 1);

        // Asynchronous reset between edges at beat 15.
        run_cycle(1'b1, 0);
        repeat (15) run_cycle(1'b0, 0);
        chk("pre_reset_beat", longint'(out_beat), 15);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        pos = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        valid_cycles = 0;
        repeat (5) run_cycle(1'b0, 0);
        chk("post_reset_valid_cycles", valid_cycles, 0);
        run_cycle(1'b1, 0);

        // Long idle period after reset: framing quiet, data still mapped.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pos = -1;
        valid_cycles = 0;
        repeat (100) run_cycle(1'b0, 0);
        chk("idle_valid_cycles", valid_cycles, 0);

        // Random traffic with occasional (sometimes premature) starts.
        for (int i = 0; i < 400; i++) run_cycle(($urandom_range(0, 19) == 0), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
